// File: rtl/fundamental_mode_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fundamental_mode_sequencer
//  Purpose  : Clocked driver for a two-input fundamental-mode asynchronous
//             state machine. Accepts a target {X2,X1} vector on a valid/ready
//             request channel, walks the async inputs toward it one bit per
//             settle window (X1 before X2), then samples the synchronized
//             {Z2,Z1} outputs and returns them on a valid/ready response
//             channel.
//  Ports    : clk, rst_n                 clock / async active-low reset
//             req_valid, req_ready, req_x request channel (target {X2,X1})
//             rsp_valid, rsp_ready,       response channel ({Z2,Z1}, number
//             rsp_z, rsp_steps,           of X bits changed, late-Z flag)
//             rsp_unstable
//             x1_out, x2_out              registered drives to the async core
//             z1_in, z2_in                unsynchronized async outputs
//             busy                        high whenever not idle
//  Options  : `define FMS_STABILITY_CHECK_EN to enable the late-Z-change
//             monitor; otherwise rsp_unstable is tied low.
//  Revision : 1.0  initial release
// ============================================================================
module fundamental_mode_sequencer #(
    parameter int SETTLE_CYCLES = 6,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_x,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [1:0] rsp_z,
    output logic [1:0] rsp_steps,
    output logic       rsp_unstable,
    output logic       x1_out,
    output logic       x2_out,
    input  logic       z1_in,
    input  logic       z2_in,
    output logic       busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STEP   = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    // Windows between two input changes run SETTLE_CYCLES cycles in SETTLE.
    // The window that ends in a sample runs one cycle longer so that the
    // last X change has fully propagated through the two-flop synchronizer.
    localparam logic [CNT_W-1:0] C_LOAD_MID  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_LOAD_LAST = CNT_W'(SETTLE_CYCLES);

    logic [1:0]       r_state;
    logic [1:0]       r_diff;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_steps;
    logic             r_x1;
    logic             r_x2;
    logic [1:0]       r_sync1;
    logic [1:0]       r_zs;
    logic             r_rsp_valid;
    logic [1:0]       r_rsp_z;
    logic [1:0]       r_rsp_steps;

    logic [1:0]       w_diff_next;
    logic             w_accept;
    logic             w_sample;

    // Lowest pending bit is served first, so X1 always moves before X2.
    always_comb begin
        w_diff_next = 2'b00;
        if (r_diff[0]) begin
            w_diff_next = {r_diff[1], 1'b0};
        end
    end

    assign w_accept = (r_state == ST_IDLE) && req_valid;
    assign w_sample = (r_state == ST_SETTLE) && (r_cnt == '0) && (r_diff == 2'b00);

    // Two-flop synchronizer for the async outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 2'b00;
            r_zs    <= 2'b00;
        end else begin
            r_sync1 <= {z2_in, z1_in};
            r_zs    <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_diff      <= 2'b00;
            r_cnt       <= '0;
            r_steps     <= 2'b00;
            r_x1        <= 1'b0;
            r_x2        <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_z     <= 2'b00;
            r_rsp_steps <= 2'b00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_diff  <= req_x ^ {r_x2, r_x1};
                        r_steps <= 2'b00;
                        r_state <= ST_STEP;
                    end
                end
                ST_STEP: begin
                    if (r_diff[0]) begin
                        r_x1 <= ~r_x1;
                    end else if (r_diff[1]) begin
                        r_x2 <= ~r_x2;
                    end
                    if (r_diff != 2'b00) begin
                        r_steps <= r_steps + 2'd1;
                    end
                    r_diff  <= w_diff_next;
                    r_cnt   <= (w_diff_next != 2'b00) ? C_LOAD_MID : C_LOAD_LAST;
                    r_state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (r_diff != 2'b00) begin
                        r_state <= ST_STEP;
                    end else begin
                        r_rsp_z     <= r_zs;
                        r_rsp_steps <= r_steps;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef FMS_STABILITY_CHECK_EN
    logic [1:0] r_zs_d;
    logic       r_unstable;
    logic       r_rsp_unstable;
    logic       w_late_change;

    // A Z change while the counter is at 1 or 0 means the core had not
    // settled by the end of the window.
    assign w_late_change = (r_state == ST_SETTLE) && (r_cnt <= CNT_W'(1)) && (r_zs != r_zs_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zs_d         <= 2'b00;
            r_unstable     <= 1'b0;
            r_rsp_unstable <= 1'b0;
        end else begin
            r_zs_d <= r_zs;
            if (w_accept) begin
                r_unstable     <= 1'b0;
                r_rsp_unstable <= 1'b0;
            end else begin
                if (w_late_change) begin
                    r_unstable <= 1'b1;
                end
                // Include a change seen in the sampling cycle itself.
                if (w_sample) begin
                    r_rsp_unstable <= r_unstable | w_late_change;
                end
            end
        end
    end

    assign rsp_unstable = r_rsp_unstable;
`else
    assign rsp_unstable = 1'b0;
`endif

    assign req_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_z     = r_rsp_z;
    assign rsp_steps = r_rsp_steps;
    assign x1_out    = r_x1;
    assign x2_out    = r_x2;

endmodule
`default_nettype wire

// File: tb/tb_fundamental_mode_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fundamental_mode_sequencer
//  Purpose  : Self-checking bench for fundamental_mode_sequencer. A
//             behavioural model derives the expected X drive sequence,
//             response timing and response contents from the target vector.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fundamental_mode_sequencer;

    localparam int S = 6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_x;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [1:0] rsp_z;
    logic [1:0] rsp_steps;
    logic       rsp_unstable;
    logic       x1_out;
    logic       x2_out;
    logic       z1_in;
    logic       z2_in;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;
    logic [1:0] m_x = 2'b00;   // model of the current {X2,X1} drive

    fundamental_mode_sequencer #(
        .SETTLE_CYCLES(S),
        .CNT_W        (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_x       (req_x),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_z       (rsp_z),
        .rsp_steps   (rsp_steps),
        .rsp_unstable(rsp_unstable),
        .x1_out      (x1_out),
        .x2_out      (x2_out),
        .z1_in       (z1_in),
        .z2_in       (z2_in),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Expected {X2,X1} j edges after the accept edge: step slot k opens at
    // edge 1+k*(S+1); each open slot flips the next differing bit, low first.
    function automatic logic [1:0] exp_x(input logic [1:0] start, input logic [1:0] tgt, input int j);
        int         slots;
        logic [1:0] d;
        logic [1:0] r;
        r = start;
        d = start ^ tgt;
        slots = 0;
        for (int k = 0; k < 2; k++) begin
            if (j >= 1 + k * (S + 1)) slots++;
        end
        for (int b = 0; b < 2; b++) begin
            if (d[b] && slots > 0) begin
                r[b] = ~r[b];
                slots--;
            end
        end
        return r;
    endfunction

    function automatic int rsp_edge(input logic [1:0] start, input logic [1:0] tgt);
        int n;
        n = $countones(start ^ tgt);
        if (n == 0) n = 1;
        return n * (S + 1) + 1;
    endfunction

    // One full transaction with model checks on every cycle.
    task automatic run_request(input logic [1:0] tgt, input logic [1:0] z, input int hold, input bit poke);
        int         trsp;
        logic [1:0] steps_exp;
        trsp      = rsp_edge(m_x, tgt);
        steps_exp = 2'($countones(m_x ^ tgt));
        n_vec++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL idle_ready: got ready=%b busy=%b, expected ready=1 busy=0", req_ready, busy);
        end
        z1_in     = z[0];
        z2_in     = z[1];
        req_x     = tgt;
        req_valid = 1'b1;
        rsp_ready = (hold == 0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_x     = 2'($urandom);
        for (int j = 1; j <= trsp; j++) begin
            @(posedge clk); #1;
            n_vec++;
            if ({x2_out, x1_out} !== exp_x(m_x, tgt, j)) begin
                n_err++;
                $display("FAIL x_drive j=%0d: got %b expected %b", j, {x2_out, x1_out}, exp_x(m_x, tgt, j));
            end
            n_vec++;
            if (rsp_valid !== (j == trsp) || busy !== 1'b1 || req_ready !== 1'b0) begin
                n_err++;
                $display("FAIL busy_timing j=%0d: got valid=%b busy=%b ready=%b expected valid=%b busy=1 ready=0",
                         j, rsp_valid, busy, req_ready, (j == trsp));
            end
            if (poke && j == 3) begin
                req_valid = 1'b1;
                req_x     = ~tgt;
            end
            if (poke && j == 4) req_valid = 1'b0;
        end
        n_vec++;
        if (rsp_z !== z || rsp_steps !== steps_exp || rsp_unstable !== 1'b0) begin
            n_err++;
            $display("FAIL rsp_data: got z=%b steps=%0d unst=%b expected z=%b steps=%0d unst=0",
                     rsp_z, rsp_steps, rsp_unstable, z, steps_exp);
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            n_vec++;
            if (rsp_valid !== 1'b1 || rsp_z !== z || rsp_steps !== steps_exp || req_ready !== 1'b0) begin
                n_err++;
                $display("FAIL backpressure h=%0d: got valid=%b z=%b steps=%0d ready=%b expected 1 %b %0d 0",
                         h, rsp_valid, rsp_z, rsp_steps, req_ready, z, steps_exp);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL handshake_done: got valid=%b ready=%b busy=%b expected 0 1 0", rsp_valid, req_ready, busy);
        end
        m_x = tgt;
    endtask

    task automatic check_reset_outputs(input string tag);
        n_vec++;
        if ({x2_out, x1_out} !== 2'b00 || rsp_valid !== 1'b0 || rsp_z !== 2'b00 || rsp_steps !== 2'b00 ||
            rsp_unstable !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s: got x=%b v=%b z=%b st=%0d u=%b busy=%b rdy=%b expected x=00 v=0 z=00 st=0 u=0 busy=0 rdy=1",
                     tag, {x2_out, x1_out}, rsp_valid, rsp_z, rsp_steps, rsp_unstable, busy, req_ready);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_x     = 2'b00;
        rsp_ready = 1'b1;
        z1_in     = 1'b0;
        z2_in     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_held");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("reset_released");
        m_x = 2'b00;
    endtask

    task automatic test_single();
        run_request(2'b01, 2'b01, 0, 1'b0);
    endtask

    task automatic test_double();
        run_request(2'b11, 2'b10, 0, 1'b0);
    endtask

    task automatic test_no_change();
        run_request(2'b11, 2'($urandom), 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_request(2'b00, 2'b11, 5, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            run_request(2'($urandom), 2'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
        end
    endtask

    task automatic test_reset_mid_settle();
        if (m_x != 2'b00) run_request(2'b00, 2'b00, 0, 1'b0);
        req_x     = 2'b11;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({x2_out, x1_out} !== 2'b01) begin
            n_err++;
            $display("FAIL mid_first_step: got %b expected 01", {x2_out, x1_out});
        end
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid_settle");
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_x   = 2'b00;
        for (int j = 0; j < 20; j++) begin
            @(posedge clk); #1;
            n_vec++;
            if (rsp_valid !== 1'b0 || {x2_out, x1_out} !== 2'b00 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL after_mid_reset j=%0d: got v=%b x=%b busy=%b expected 0 00 0",
                         j, rsp_valid, {x2_out, x1_out}, busy);
            end
        end
    endtask

`ifdef FMS_STABILITY_CHECK_EN
    // No-change request; Z moves so the synchronized value changes while
    // the final window counter sits at 1.
    task automatic test_unstable();
        int trsp;
        z1_in     = 1'b0;
        z2_in     = 1'b0;
        rsp_ready = 1'b1;
        trsp      = rsp_edge(m_x, m_x);
        req_x     = m_x;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int j = 1; j <= trsp; j++) begin
            @(posedge clk); #1;
            if (j == 4) begin
                z1_in = 1'b1;
                z2_in = 1'b1;
            end
        end
        n_vec++;
        if (rsp_valid !== 1'b1 || rsp_unstable !== 1'b1 || rsp_z !== 2'b11) begin
            n_err++;
            $display("FAIL unstable_flag: got v=%b u=%b z=%b expected 1 1 11", rsp_valid, rsp_unstable, rsp_z);
        end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_double();
        test_no_change();
        test_backpressure();
        test_random();
        test_reset_mid_settle();
`ifdef FMS_STABILITY_CHECK_EN
        test_unstable();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
